store_buffer: RTL
=================

Name: store_buffer

Overview:
- Store-side counterpart of the MEM-stage load path: accepts committed stores (SB/SH/SW/SWL/SWR) from the pipeline and aligns data to byte lanes. Generates byte strobes and queues entries in a small FIFO.
- Drains the FIFO to the data SRAM-like bus with a req/addr_ok/data_ok handshake.
- Flags loads whose word address hits a pending store, so the pipeline stalls instead of reading stale data.

Parameters:
- DEPTH, 4, FIFO entries (power of two, at least 2)
- AW, 2, pointer width, equal to log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- st_valid  in  1  store presented this cycle
- st_op  in  5  one-hot: [0]SB [1]SH [2]SW [3]SWL [4]SWR
- st_addr  in  32  byte address
- st_wdata  in  32  unaligned rt value
- st_flush  in  1  discard the presented store
- st_stall_o  out  1  store cannot be accepted this cycle
- ld_valid  in  1  load in MEM stage
- ld_addr  in  32  load byte address
- ld_conflict_o  out  1  load word matches a pending store entry
- data_req  out  1  bus request
- data_wr  out  1  constant 1 while data_req is high
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  bus address
- data_wstrb  out  4  byte enables
- data_wdata  out  32  lane-aligned write data
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  write completed
- sb_empty_o  out  1  FIFO empty and no bus transaction in flight

Behaviour:
- Reset (async, rst=1): all entries invalidated, pointers=0, count=0, FSM=IDLE, data_req=0, st_stall_o=0, ld_conflict_o=0, sb_empty_o=1.
  - Reset is legal mid-transaction; the outstanding bus write is abandoned.
- Push condition: st_valid & |st_op & !st_flush & (count!=DEPTH) on a rising edge. The entry is written at wptr and wptr wraps mod DEPTH.
- st_stall_o = st_valid & !st_flush & (count==DEPTH). Full is judged on registered count, so a same-cycle pop does not free a slot for that cycle's push.
- Alignment is done at push; a = st_addr[1:0], rt = st_wdata. Each entry stores addr, size, strb, data.
  - SB: data {4{rt[7:0]}}; strb 0001<<a; size 0; addr unchanged.
  - SH: data {2{rt[15:0]}}; strb 0011 if a[1]=0, else 1100; size 1; addr unchanged.
  - SW: data rt; strb 1111; size 2.
  - SWL, a=00/01/10/11: strb 0001/0011/0111/1111; data {24'b0,rt[31:24]} / {16'b0,rt[31:16]} / {8'b0,rt[31:8]} / rt.
  - SWR, a=00/01/10/11: strb 1111/1110/1100/1000; data rt / {rt[23:0],8'b0} / {rt[15:0],16'b0} / {rt[7:0],24'b0}.
  - SW, SWL, SWR: size 2; addr = {st_addr[31:2],2'b00}.
- Drain FSM, one outstanding write:
  - IDLE: if count>0, go to REQ.
  - REQ: data_req=1 with the head entry's fields held stable. On data_addr_ok go to WAIT and drop data_req the next cycle.
  - WAIT: on data_data_ok, pop the head (rptr+1 mod DEPTH, count-1). Go to REQ if count after pop > 0, else IDLE.
  - data_addr_ok and data_data_ok in the same cycle while in REQ: treat as accept plus complete. Pop, and skip WAIT.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- ld_conflict_o is combinational: ld_valid & (some valid entry, including the in-flight head, has addr[31:2]==ld_addr[31:2]).
  - It does not compare against the store presented in the same cycle.
  - It drops in the cycle after the matching entry is popped.
- sb_empty_o = (count==0) & (FSM==IDLE).
- data_size, data_addr, data_wstrb, data_wdata are don't-care while data_req=0. They are driven from the head entry.

Test Plan:
- SB at 0x1003, rt=0x000000AB, immediate addr_ok then data_ok 2 cycles later -> data_wdata=0xABABABAB, wstrb=1000, size=0, addr=0x1003; sb_empty_o back to 1 after data_ok.
- SWL at 0x2001 with rt=0x11223344, then SWR at 0x2001 with the same rt -> entry 0: wstrb 0011, data 0x00001122, addr 0x2000; entry 1: wstrb 1110, data 0x22334400; both issued in order.
- data_addr_ok held low: push 4 SW, then a 5th -> st_stall_o=1 on the 5th, count stays 4. After the first data_ok, the 5th store is accepted the following cycle.
- SW pending at 0x3008, load at 0x300A -> ld_conflict_o=1 until the data_ok cycle of that entry. Load at 0x300C -> 0.
- st_flush with st_valid=1 -> nothing pushed, st_stall_o=0, count unchanged.
- rst asserted in WAIT with 3 entries -> data_req=0 and sb_empty_o=1 immediately. After release, a new SH at 0x4002 with rt=0x0000BEEF -> data 0xBEEFBEEF, strb 1100.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: aligns committed stores to byte lanes, queues them in a FIFO,
// and drains them to the data bus one write at a time.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [4:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic        st_flush,
    output logic        st_stall_o,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        sb_empty_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PONE = AW'(1);

    state_e state_q, state_d;

    logic [31:0] addr_q [DEPTH];
    logic [1:0]  size_q [DEPTH];
    logic [3:0]  strb_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;

    logic        push, pop;
    logic        full;
    logic [31:0] al_addr;
    logic [1:0]  al_size;
    logic [3:0]  al_strb;
    logic [31:0] al_data;
    logic [1:0]  a;
    logic [31:0] rt;

    assign a    = st_addr[1:0];
    assign rt   = st_wdata;
    assign full = (count_q == FULL);

    assign push = st_valid & (|st_op) & ~st_flush & ~full;
    assign pop  = ((state_q == S_REQ) & data_addr_ok & data_data_ok)
                | ((state_q == S_WAIT) & data_data_ok);

    assign st_stall_o = st_valid & ~st_flush & full;

    // Lane alignment happens once at push so the bus side just replays fields.
    always_comb begin
        al_addr = {st_addr[31:2], 2'b00};
        al_size = 2'd2;
        al_strb = 4'b1111;
        al_data = rt;
        case (1'b1)
            st_op[0]: begin
                al_addr = st_addr;
                al_size = 2'd0;
                al_strb = 4'b0001 << a;
                al_data = {4{rt[7:0]}};
            end
            st_op[1]: begin
                al_addr = st_addr;
                al_size = 2'd1;
                al_strb = a[1] ? 4'b1100 : 4'b0011;
                al_data = {2{rt[15:0]}};
            end
            st_op[2]: begin
                al_strb = 4'b1111;
                al_data = rt;
            end
            st_op[3]: begin
                case (a)
                    2'b00: begin
                        al_strb = 4'b0001;
                        al_data = {24'b0, rt[31:24]};
                    end
                    2'b01: begin
                        al_strb = 4'b0011;
                        al_data = {16'b0, rt[31:16]};
                    end
                    2'b10: begin
                        al_strb = 4'b0111;
                        al_data = {8'b0, rt[31:8]};
                    end
                    default: begin
                        al_strb = 4'b1111;
                        al_data = rt;
                    end
                endcase
            end
            st_op[4]: begin
                case (a)
                    2'b00: begin
                        al_strb = 4'b1111;
                        al_data = rt;
                    end
                    2'b01: begin
                        al_strb = 4'b1110;
                        al_data = {rt[23:0], 8'b0};
                    end
                    2'b10: begin
                        al_strb = 4'b1100;
                        al_data = {rt[15:0], 16'b0};
                    end
                    default: begin
                        al_strb = 4'b1000;
                        al_data = {rt[7:0], 24'b0};
                    end
                endcase
            end
            default: begin
                al_addr = st_addr;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + ONE;
        end else if (pop && !push) begin
            count_d = count_q - ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = (count_d != '0) ? S_REQ : S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d = (count_d != '0) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (pop) begin
                valid_q[rptr_q] <= 1'b0;
                rptr_q          <= rptr_q + PONE;
            end
            if (push) begin
                valid_q[wptr_q] <= 1'b1;
                wptr_q          <= wptr_q + PONE;
            end
        end
    end

    // Payload needs no reset; valid_q alone marks live entries.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wptr_q] <= al_addr;
            size_q[wptr_q] <= al_size;
            strb_q[wptr_q] <= al_strb;
            data_q[wptr_q] <= al_data;
        end
    end

    always_comb begin
        ld_conflict_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) begin
                ld_conflict_o = ld_valid;
            end
        end
    end

    assign data_req   = (state_q == S_REQ);
    assign data_wr    = data_req;
    assign data_size  = size_q[rptr_q];
    assign data_addr  = addr_q[rptr_q];
    assign data_wstrb = strb_q[rptr_q];
    assign data_wdata = data_q[rptr_q];

    assign sb_empty_o = (count_q == '0) & (state_q == S_IDLE);

endmodule
